// File: rtl/packet_assembler_pkg.sv
// Shared SPI_v3 component types and helpers for the packet assembler/disassembler pair.
package packet_assembler_pkg;

  // Assembler FSM: FILL collects chunks, FULL holds a complete packet.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // Ceiling division: number of small chunks needed to cover a big word.
  function automatic int unsigned num_chunks(input int unsigned nbits_big,
                                             input int unsigned nbits_small);
    return (nbits_big + nbits_small - 1) / nbits_small;
  endfunction

endpackage

// File: rtl/packet_assembler_ctrl.sv
// Packet assembler control: FILL/FULL FSM, chunk counter, rdy/val and
// per-register write enables. Optional flush port under PACKET_ASSEMBLER_FLUSH_EN.
module packet_assembler_ctrl
  import packet_assembler_pkg::*;
#(
  parameter int unsigned num_regs = 2,
  parameter int unsigned cnt_bits = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recv_val,
  input  logic                send_rdy,
`ifdef PACKET_ASSEMBLER_FLUSH_EN
  input  logic                flush,
`endif
  output logic                recv_rdy_c,
  output logic                send_val,
  output logic [num_regs-1:0] wr_en_c
);

  localparam logic [cnt_bits-1:0] LastIdx = cnt_bits'(num_regs - 1);

  state_e              state_q, state_d;
  logic [cnt_bits-1:0] cnt_q, cnt_d;
  logic [cnt_bits-1:0] chunk_idx_c;
  logic                fire_c;
  logic                flush_c;

`ifdef PACKET_ASSEMBLER_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Valid is a straight decode of the state flop.
  assign send_val = (state_q == FULL);

  // Next state, counter, ready and write-enable generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_c     = '0;
    chunk_idx_c = cnt_q;
    recv_rdy_c  = (state_q == FILL) | send_rdy;
    fire_c      = recv_val & recv_rdy_c;

    case (state_q)
      FILL: begin
        // Flush abandons the partial packet; a same-cycle chunk restarts at index 0.
        if (flush_c) begin
          chunk_idx_c = '0;
          cnt_d       = '0;
        end
        if (fire_c) begin
          for (int unsigned i = 0; i < num_regs; i++) begin
            wr_en_c[i] = (32'(chunk_idx_c) + i == num_regs - 1);
          end
          if (chunk_idx_c == LastIdx) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = chunk_idx_c + cnt_bits'(1);
          end
        end
      end
      FULL: begin
        // Departing packet may overlap with chunk 0 of the next one.
        if (send_rdy) begin
          if (recv_val) begin
            wr_en_c[num_regs-1] = 1'b1;
            if (num_regs == 1) begin
              state_d = FULL;
              cnt_d   = '0;
            end else begin
              state_d = FILL;
              cnt_d   = cnt_bits'(1);
            end
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/packet_assembler.sv
// Packet assembler: gathers MSB-first nbits_in chunks into one nbits_out packet.
// Optional flush input enabled by defining PACKET_ASSEMBLER_FLUSH_EN.
module packet_assembler
  import packet_assembler_pkg::*;
#(
  parameter int unsigned nbits_in  = 8,
  parameter int unsigned nbits_out = 16,
  parameter int unsigned num_regs  = num_chunks(nbits_out, nbits_in),
  parameter int unsigned cnt_bits  = $clog2(num_regs) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [nbits_in-1:0]  recv_msg,
`ifdef PACKET_ASSEMBLER_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [nbits_out-1:0] send_msg
);

  logic [num_regs-1:0]          wr_en_c;
  logic [nbits_in-1:0]          regs_q [num_regs];
  logic [nbits_in-1:0]          regs_d [num_regs];
  logic [num_regs*nbits_in-1:0] cat_c;

  packet_assembler_ctrl #(
    .num_regs (num_regs),
    .cnt_bits (cnt_bits)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .recv_val   (recv_val),
    .send_rdy   (send_rdy),
`ifdef PACKET_ASSEMBLER_FLUSH_EN
    .flush      (flush),
`endif
    .recv_rdy_c (recv_rdy),
    .send_val   (send_val),
    .wr_en_c    (wr_en_c)
  );

  // Data registers load only when their write enable fires.
  always_comb begin
    for (int i = 0; i < int'(num_regs); i++) begin
      regs_d[i] = wr_en_c[i] ? recv_msg : regs_q[i];
    end
  end

  // Data register array with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(num_regs); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(num_regs); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Concatenate reg[num_regs-1]..reg[0]; truncation drops the unused top bits.
  always_comb begin
    for (int i = 0; i < int'(num_regs); i++) begin
      cat_c[i*nbits_in +: nbits_in] = regs_q[i];
    end
  end

  assign send_msg = cat_c[nbits_out-1:0];

endmodule

// File: tb/tb_packet_assembler.sv
// Self-checking bench for packet_assembler: an 8->16 and an 8->12 instance
// share stimulus and are compared against a chunk-queue reference model.
module tb_packet_assembler;

`ifdef PACKET_ASSEMBLER_FLUSH_EN
  localparam bit FlushOn = 1'b1;
`else
  localparam bit FlushOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val;
  logic [7:0]  recv_msg;
  logic        send_rdy;
  logic        flush_i;
  logic        recv_rdy, recv_rdy12;
  logic        send_val, send_val12;
  logic [15:0] send_msg;
  logic [11:0] send_msg12;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: accepted chunks of the packet in progress, plus a held packet.
  logic [7:0]  partial[$];
  bit          held_v   = 1'b0;
  logic [15:0] held_pkt = '0;
  bit          model_ok = 1'b0;

  always #5 clk = ~clk;

  packet_assembler #(.nbits_in(8), .nbits_out(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
`ifdef PACKET_ASSEMBLER_FLUSH_EN
    .flush    (flush_i),
`endif
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg)
  );

  packet_assembler #(.nbits_in(8), .nbits_out(12)) dut12 (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy12),
    .recv_msg (recv_msg),
`ifdef PACKET_ASSEMBLER_FLUSH_EN
    .flush    (flush_i),
`endif
    .send_val (send_val12),
    .send_rdy (send_rdy),
    .send_msg (send_msg12)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input logic rv, input logic [7:0] m, input logic sr,
                      input logic rst, input logic fl);
    bit exp_rdy;
    bit fire;
    bit was_held;
    recv_val = rv;
    recv_msg = m;
    send_rdy = sr;
    reset    = rst;
    flush_i  = fl;
    #1;
    exp_rdy = !held_v || sr;
    if (model_ok) begin
      check("recv_rdy", 16'(recv_rdy), 16'(exp_rdy));
      check("recv_rdy12", 16'(recv_rdy12), 16'(exp_rdy));
      check("send_val", 16'(send_val), 16'(held_v));
      check("send_val12", 16'(send_val12), 16'(held_v));
      if (held_v) begin
        check("send_msg", send_msg, held_pkt);
        check("send_msg12", 16'(send_msg12), 16'(held_pkt[11:0]));
      end
    end
    @(posedge clk);
    if (rst) begin
      partial.delete();
      held_v   = 1'b0;
      model_ok = 1'b1;
    end else begin
      was_held = held_v;
      fire     = rv && exp_rdy;
      if (held_v && sr) held_v = 1'b0;
      if (fl && !was_held) partial.delete();
      if (fire) partial.push_back(m);
      if (partial.size() == 2) begin
        held_pkt = {partial[0], partial[1]};
        held_v   = 1'b1;
        partial.delete();
      end
    end
    #1;
  endtask

  initial begin
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b0;
    reset    = 1'b1;
    flush_i  = 1'b0;

    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // Reset state: FILL, registers cleared.
    recv_val = 1'b0;
    send_rdy = 1'b0;
    reset    = 1'b0;
    #1;
    check("rst_send_val", 16'(send_val), 16'd0);
    check("rst_recv_rdy", 16'(recv_rdy), 16'd1);
    check("rst_send_msg", send_msg, 16'h0000);
    check("rst_send_msg12", 16'(send_msg12), 16'h000);

    // Basic packet, latency one cycle after last chunk.
    step(1, 8'hAB, 1, 0, 0);
    step(1, 8'hCD, 1, 0, 0);
    check("basic_msg", send_msg, 16'hABCD);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Back-to-back chunks at full rate.
    step(1, 8'h12, 1, 0, 0);
    step(1, 8'h34, 1, 0, 0);
    check("b2b_msg0", send_msg, 16'h1234);
    step(1, 8'h56, 1, 0, 0);
    step(1, 8'h78, 1, 0, 0);
    check("b2b_msg1", send_msg, 16'h5678);
    step(0, 8'h00, 1, 0, 0);

    // Backpressure: held packet stable, incoming chunks refused.
    step(1, 8'hBE, 1, 0, 0);
    step(1, 8'hEF, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h77, 0, 0, 0);
    check("bp_msg", send_msg, 16'hBEEF);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Non-multiple width: upper nibble of first chunk dropped in the 12-bit instance.
    step(1, 8'hFA, 1, 0, 0);
    step(1, 8'hBC, 1, 0, 0);
    check("nonmult_msg12", 16'(send_msg12), 16'h0ABC);
    step(0, 8'h00, 1, 0, 0);

    // Reset mid-packet discards the partial chunk.
    step(1, 8'h11, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    step(1, 8'h22, 1, 0, 0);
    step(1, 8'h33, 1, 0, 0);
    check("rstmid_msg", send_msg, 16'h2233);
    step(0, 8'h00, 1, 0, 0);

`ifdef PACKET_ASSEMBLER_FLUSH_EN
    // Flush abandons a partial packet but never a full one.
    step(1, 8'h99, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'h44, 1, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    check("flush_msg", send_msg, 16'h4455);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    check("flush_full_msg", send_msg, 16'h4455);
    step(0, 8'h00, 1, 0, 0);
`endif

    // Randomized traffic with occasional reset and flush.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           8'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 49) == 0),
           FlushOn && ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
